// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial W-bit adder sharing one full-adder cell across all bits

// Half adder cell; two of these plus an OR form the shared full adder.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         carry_out
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] ra, rb, rs, rs_nx;
  logic [CW-1:0] cnt;
  logic c, s, s1, c1, c2, co;
  half_adder ha1 (.x(ra[0]), .y(rb[0]), .s(s1), .c(c1));
  half_adder ha2 (.x(s1), .y(c), .s(s), .c(c2));
  assign co = c1 | c2;
  if (W == 1) begin : g_one
    assign rs_nx = s;
  end else begin : g_wide
    assign rs_nx = {s, rs[W-1:1]};
  end
  // Next state: accept in IDLE, finish after the W-th bit step, release on downstream accept
  always_comb begin
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (cnt == CW'(W - 1) ? DONE : RUN) :
          state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // State register and datapath: load operands on accept, one bit per cycle during RUN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        ra  <= a;
        rb  <= b;
        rs  <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        ra  <= ra >> 1;
        rb  <= rb >> 1;
        rs  <= rs_nx;
        c   <= co;
        cnt <= cnt + CW'(1);
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum       = rs;
  assign carry_out = c;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench over W=8, W=1 and W=32 instances
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rstn;
  logic iv[3], ir[3], ovl[3], ordy[3], co[3];
  logic [31:0] av[3], bv[3], so[3];
  logic [32:0] q[$];
  int tot = 0;
  int pass_n = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int WG = g == 0 ? 8 : g == 1 ? 1 : 32;
    logic [WG-1:0] s;
    serial_adder_ctrl #(.W(WG)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .a(av[g][WG-1:0]), .b(bv[g][WG-1:0]),
      .out_valid(ovl[g]), .out_ready(ordy[g]),
      .sum(s), .carry_out(co[g])
    );
    assign so[g] = 32'(s);
  end

  function automatic int wid(input int g);
    return g == 0 ? 8 : g == 1 ? 1 : 32;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain W+1-bit addition of the masked operands
  function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] m;
    logic [63:0] e;
    m = w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    e = 64'(x & m) + 64'(y & m);
    return {e[w], e[31:0] & m};
  endfunction

  // Monitor: every result transfer must match the oldest queued expectation
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++)
      if (rstn && ovl[g] === 1'b1 && ordy[g] === 1'b1) begin
        if (q.size() == 0) chk("spurious_valid", 64'(ovl[g]), 64'd0);
        else chk("result", 64'({co[g], so[g]}), 64'(q.pop_front()));
      end
  end

  task automatic op(input int g, input logic [31:0] x, input logic [31:0] y, input int hold);
    int w, n, lo;
    logic [32:0] e;
    w = wid(g);
    e = model(w, x, y);
    n = 0;
    while (ir[g] !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("idle_ready", 64'(ir[g]), 64'd1);
    av[g] = x; bv[g] = y; iv[g] = 1'b1; ordy[g] = hold == 0;
    q.push_back(e);
    @(posedge clk); #1;
    iv[g] = 1'b0;
    n = 0; lo = 0;
    while (ovl[g] !== 1'b1 && n < 100) begin
      if (ir[g] === 1'b0) lo++;
      av[g] = $urandom; bv[g] = $urandom;
      @(posedge clk); #1; n++;
    end
    if (ir[g] === 1'b0) lo++;
    chk("latency", 64'(n), 64'(w));
    if (hold == 0) chk("ready_low_cycles", 64'(lo), 64'(w + 1));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 64'({ovl[g], ir[g]}), 64'b10);
      chk("hold_result", 64'({co[g], so[g]}), 64'(e));
      iv[g] = 1'b1; av[g] = $urandom; bv[g] = $urandom;
      @(posedge clk); #1;
    end
    iv[g] = 1'b0; ordy[g] = 1'b1;
    @(posedge clk); #1;
    chk("ready_after", 64'({ir[g], ovl[g]}), 64'b10);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        iv[g] = 1'($urandom); ordy[g] = 1'($urandom); av[g] = $urandom; bv[g] = $urandom;
      end
      @(posedge clk); #1;
    end
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", 64'(ir[g]), 64'd1);
      chk("rst_out_valid", 64'(ovl[g]), 64'd0);
      chk("rst_sum", 64'(so[g]), 64'd0);
      chk("rst_carry", 64'(co[g]), 64'd0);
      iv[g] = 1'b0; ordy[g] = 1'b1;
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    op(0, 32'h00, 32'h00, 0);
    op(0, 32'hA5, 32'h5A, 0);
    op(0, 32'hFF, 32'h01, 0);
    op(0, 32'hFF, 32'hFF, 0);
    op(0, 32'h3C, 32'h0F, 5);
    av[0] = 32'h80; bv[0] = 32'h80; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("midrst_running", 64'(ir[0]), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 64'({ir[0], ovl[0]}), 64'b10);
    chk("midrst_sum", 64'({co[0], so[0]}), 64'd0);
    rstn = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 64'(ovl[0]), 64'd0);
    end
    op(0, 32'h01, 32'h02, 0);
    op(0, 32'h12, 32'h34, 0);
    op(1, 32'h1, 32'h1, 0);
    op(2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    op(2, 32'h8000_0000, 32'h8000_0000, 2);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 1000; i++) op(g, $urandom, $urandom, int'($urandom_range(0, 2)));
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
